// File: rtl/spi_arb_pkg.sv
// Shared types and default sizing for the SPI transmit arbiter.
package spi_arb_pkg;

  localparam int unsigned NREQ_DEF    = 4;
  localparam int unsigned DW_DEF      = 8;
  localparam int unsigned ACK_TO_DEF  = 64;
  localparam int unsigned DONE_TO_DEF = 1024;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } arb_state_t;

  // Counter width able to hold 0..max(a,b)-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/spi_tx_arbiter_rr_pick.sv
// Round-robin pick: first asserted request at or after ptr, wrapping.
module rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [PW-1:0]   gnt_idx,
  output logic            any
);

  logic [PW-1:0] idx;

  // Scan offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    gnt_idx = '0;
    any     = 1'b0;
    idx     = '0;
    for (int k = int'(NREQ) - 1; k >= 0; k--) begin
      idx = PW'((int'(ptr) + k) % int'(NREQ));
      if (req[idx]) begin
        gnt_idx = idx;
        any     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_tx_arbiter.sv
// Round-robin arbiter sharing one byte-serial SPI transmitter among NREQ clients.
module spi_tx_arbiter
  import spi_arb_pkg::*;
#(
  parameter int unsigned NREQ    = NREQ_DEF,
  parameter int unsigned DW      = DW_DEF,
  parameter int unsigned ACK_TO  = ACK_TO_DEF,
  parameter int unsigned DONE_TO = DONE_TO_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic [NREQ-1:0]    req_done,
  output logic [NREQ-1:0]    req_err,
  output logic               m_start,
  output logic [DW-1:0]      m_data,
  input  logic               m_busy,
  output logic [NREQ-1:0]    sel,
  output logic               busy
);

  localparam int unsigned PW = (NREQ < 2) ? 1 : $clog2(NREQ);
  localparam int unsigned CW = cnt_width(ACK_TO, DONE_TO);
  localparam logic [NREQ-1:0] ONE = NREQ'(1);
  localparam logic [CW-1:0] ACK_LAST  = CW'(ACK_TO - 1);
  localparam logic [CW-1:0] DONE_LAST = CW'(DONE_TO - 1);

  arb_state_t    state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] own;
  logic [CW-1:0] cnt;
  logic [PW-1:0] pick_idx;
  logic          pick_any;
  logic          grant_c;
  logic [PW-1:0] ptr_nxt;

  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req     (req_valid),
    .ptr     (ptr),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  // A grant is offered only when idle and the transmitter is quiet.
  assign grant_c   = (state == IDLE) && !m_busy && pick_any;
  assign req_ready = grant_c ? (ONE << pick_idx) : '0;
  assign busy      = (state != IDLE);
  assign ptr_nxt   = (own == PW'(NREQ - 1)) ? '0 : own + PW'(1);

  // Arbitration FSM with frame timeout counter and result pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      own      <= '0;
      cnt      <= '0;
      m_start  <= 1'b0;
      m_data   <= '0;
      sel      <= '0;
      req_done <= '0;
      req_err  <= '0;
    end else begin
      req_done <= '0;
      req_err  <= '0;
      case (state)
        IDLE: begin
          if (grant_c) begin
            own     <= pick_idx;
            sel     <= ONE << pick_idx;
            m_data  <= req_data[pick_idx*DW +: DW];
            cnt     <= '0;
            m_start <= 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          if (m_busy) begin
            m_start <= 1'b0;
            cnt     <= '0;
            state   <= WAIT_DONE;
          end else if (cnt == ACK_LAST) begin
            m_start <= 1'b0;
            req_err <= ONE << own;
            ptr     <= ptr_nxt;
            sel     <= '0;
            state   <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WAIT_DONE: begin
          if (!m_busy) begin
            req_done <= ONE << own;
            ptr      <= ptr_nxt;
            sel      <= '0;
            state    <= IDLE;
          end else if (cnt == DONE_LAST) begin
            req_err <= ONE << own;
            ptr     <= ptr_nxt;
            sel     <= '0;
            state   <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Directed bench for spi_tx_arbiter: vector table plus corner-case sequences.
module tb_spi_tx_arbiter;

  localparam int unsigned NREQ    = 4;
  localparam int unsigned DW      = 8;
  localparam int unsigned ACK_TO  = 64;
  localparam int unsigned DONE_TO = 1024;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [3:0]  req_done;
  logic [3:0]  req_err;
  logic        m_start;
  logic [7:0]  m_data;
  logic        m_busy;
  logic [3:0]  sel;
  logic        busy;

  int n_vec;
  int n_err;

  typedef struct {
    logic [3:0]  mask;
    logic [31:0] data;
    int          idx;
    int          rise;   // cycles from ISSUE entry to busy rising; <0 = never
    int          len;    // cycles busy stays high
  } vec_t;

  vec_t vt[11];

  spi_tx_arbiter #(
    .NREQ    (NREQ),
    .DW      (DW),
    .ACK_TO  (ACK_TO),
    .DONE_TO (DONE_TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .req_done  (req_done),
    .req_err   (req_err),
    .m_start   (m_start),
    .m_data    (m_data),
    .m_busy    (m_busy),
    .sel       (sel),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Present a request and wait (bounded) for the handshake edge.
  task automatic handshake(input logic [3:0] mask, input logic [31:0] data, output logic [3:0] g);
    req_data  = data;
    req_valid = mask;
    #1;
    for (int i = 0; i < 100 && (req_ready & req_valid) == 4'b0; i++) begin
      @(negedge clk);
      #1;
    end
    if ((req_ready & req_valid) == 4'b0) begin
      n_vec++;
      n_err++;
      $display("FAIL hs_timeout: got ready %b want a grant", req_ready);
    end
    g = req_ready;
    @(posedge clk);
    #1;
    req_valid = 4'b0;
  endtask

  // One full grant: handshake, issue, and either completion or ack timeout.
  task automatic run_vec(input vec_t v);
    logic [3:0] g;
    logic [3:0] exp_g;
    logic [7:0] exp_b;
    exp_g = 4'b0001 << v.idx;
    exp_b = v.data[v.idx*8 +: 8];
    handshake(v.mask, v.data, g);
    chk("grant", 32'(g), 32'(exp_g));
    @(negedge clk);
    chk("sel", 32'(sel), 32'(exp_g));
    chk("m_data", 32'(m_data), 32'(exp_b));
    chk("m_start_on", 32'(m_start), 32'd1);
    chk("busy_on", 32'(busy), 32'd1);
    chk("ready_off", 32'(req_ready), 32'd0);
    if (v.rise < 0) begin
      repeat (ACK_TO - 1) @(negedge clk);
      chk("ack_err_early", 32'(req_err), 32'd0);
      @(negedge clk);
      chk("ack_err", 32'(req_err), 32'(exp_g));
      chk("ack_no_done", 32'(req_done), 32'd0);
      chk("ack_idle", 32'(busy), 32'd0);
      chk("ack_sel", 32'(sel), 32'd0);
      chk("ack_start", 32'(m_start), 32'd0);
      @(negedge clk);
      chk("ack_err_1cyc", 32'(req_err), 32'd0);
    end else begin
      repeat (v.rise - 1) @(negedge clk);
      chk("start_held", 32'(m_start), 32'd1);
      m_busy = 1'b1;
      @(negedge clk);
      chk("start_drop", 32'(m_start), 32'd0);
      chk("busy_wait", 32'(busy), 32'd1);
      repeat (v.len - 1) @(negedge clk);
      chk("no_early_pulse", 32'(req_done | req_err), 32'd0);
      m_busy = 1'b0;
      @(negedge clk);
      chk("done", 32'(req_done), 32'(exp_g));
      chk("no_err", 32'(req_err), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_sel", 32'(sel), 32'd0);
      @(negedge clk);
      chk("done_1cyc", 32'(req_done), 32'd0);
    end
  endtask

  initial begin
    logic [3:0] g;
    vec_t       v;
    n_vec     = 0;
    n_err     = 0;
    rst       = 1'b1;
    req_valid = 4'b0;
    req_data  = 32'h0;
    m_busy    = 1'b0;

    vt[0]  = '{4'b0100, 32'h00A5_0000, 2, 30, 240};
    vt[1]  = '{4'b1111, 32'h4433_2211, 3, 2, 5};
    vt[2]  = '{4'b1111, 32'h4433_2211, 0, 2, 5};
    vt[3]  = '{4'b1111, 32'h4433_2211, 1, 2, 5};
    vt[4]  = '{4'b1111, 32'h4433_2211, 2, 2, 5};
    vt[5]  = '{4'b1111, 32'h4433_2211, 3, 2, 5};
    vt[6]  = '{4'b1111, 32'h4433_2211, 0, 1, 3};
    vt[7]  = '{4'b0010, 32'h0000_5A00, 1, -1, 0};
    vt[8]  = '{4'b0001, 32'h0000_00C3, 0, 3, 6};
    vt[9]  = '{4'b1001, 32'h7E00_0081, 3, 2, 4};
    vt[10] = '{4'b1001, 32'h7E00_0081, 0, 2, 4};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_start", 32'(m_start), 32'd0);
    chk("rst_data", 32'(m_data), 32'd0);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pulses", 32'({req_done, req_err, req_ready}), 32'd0);

    for (int i = 0; i < 11; i++) run_vec(vt[i]);

    // Done timeout: busy stuck high, then grants held off until it falls.
    handshake(4'b0100, 32'h003C_0000, g);
    chk("dto_grant", 32'(g), 32'h4);
    @(negedge clk);
    repeat (2) @(negedge clk);
    m_busy = 1'b1;
    @(negedge clk);
    chk("dto_start_drop", 32'(m_start), 32'd0);
    repeat (DONE_TO - 1) @(negedge clk);
    chk("dto_err_early", 32'(req_err), 32'd0);
    @(negedge clk);
    chk("dto_err", 32'(req_err), 32'h4);
    chk("dto_no_done", 32'(req_done), 32'd0);
    chk("dto_idle", 32'(busy), 32'd0);
    req_valid = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      chk("dto_blocked", 32'({req_ready, sel, 3'b0, busy}), 32'd0);
    end
    m_busy = 1'b0;
    #1;
    chk("dto_regrant_ready", 32'(req_ready), 32'h1);
    v = '{4'b0001, 32'h0000_0099, 0, 2, 4};
    run_vec(v);

    // Reset during WAIT_DONE: no pulse, ptr back to 0, stale busy blocks grants.
    handshake(4'b1000, 32'h6600_0000, g);
    chk("rst_grant", 32'(g), 32'h8);
    @(negedge clk);
    m_busy = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_in_wait", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstw_start", 32'(m_start), 32'd0);
    chk("rstw_data", 32'(m_data), 32'd0);
    chk("rstw_sel", 32'(sel), 32'd0);
    chk("rstw_busy", 32'(busy), 32'd0);
    chk("rstw_pulses", 32'({req_done, req_err}), 32'd0);
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("rstw_blocked", 32'({req_ready, req_done, req_err}), 32'd0);
    end
    m_busy = 1'b0;
    #1;
    chk("rstw_ptr0", 32'(req_ready), 32'h1);
    v = '{4'b1111, 32'h1234_5678, 0, 2, 4};
    run_vec(v);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
